// File: rtl/alu_z_unit_pkg.sv
// alu_z_unit_pkg: operation encodings and control states shared by the ALU/Z stage
package alu_z_unit_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd3,
        OP_SUB  = 5'd4,
        OP_AND  = 5'd5,
        OP_OR   = 5'd6,
        OP_SHR  = 5'd7,
        OP_SHRA = 5'd8,
        OP_SHL  = 5'd9,
        OP_ROR  = 5'd10,
        OP_ROL  = 5'd11,
        OP_MUL  = 5'd15,
        OP_DIV  = 5'd16,
        OP_NEG  = 5'd17,
        OP_NOT  = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, MUL_ITER, DIV_ITER, DIV_FIX} state_e;

endpackage

// File: rtl/alu_z_unit_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, done pulses after W steps
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          run;
    logic [W:0]    sh;
    logic [W:0]    trial;
    logic          neg;

    // shift next dividend bit into the partial remainder and try subtracting the divisor
    always_comb begin
        sh    = {remainder, quotient[W-1]};
        trial = sh - {1'b0, dvs};
        neg   = sh < {1'b0, dvs};
    end

    // iteration state; the quotient register doubles as the dividend shifter
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
            cnt       <= '0;
            run       <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
            cnt       <= '0;
            run       <= 1'b1;
            done      <= 1'b0;
        end else if (run) begin
            remainder <= neg ? W'(sh) : W'(trial);
            quotient  <= {quotient[W-2:0], ~neg};
            cnt       <= cnt + 1'b1;
            run       <= cnt != CW'(W - 1);
            done      <= cnt == CW'(W - 1);
        end else begin
            done      <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_z_unit.sv
// alu_z_unit: Y operand latch, ALU with iterative Booth multiply and signed divide, Z result register
module alu_z_unit
    import alu_z_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ITER   = DATA_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              Yin,
    input  logic              start,
    input  logic [4:0]        alu_op,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] ZHi_Data_Out,
    output logic [DATA_W-1:0] ZLo_Data_Out
);
    localparam int CW = $clog2(ITER + 1);
    localparam int SW = $clog2(DATA_W);

    state_e              state, state_nx;
    logic [DATA_W-1:0]   y, m_reg, alu_lo, a_mag, b_mag, quo, rem, quo_fix, rem_fix;
    logic [2*DATA_W-1:0] z, z_nx;
    logic [2*DATA_W+1:0] p, p_step;
    logic [DATA_W:0]     acc, acc_nx, m_ext;
    logic [CW-1:0]       cnt;
    logic [SW-1:0]       sh;
    logic                a_neg, b_neg, accept, div_go, div_done, mul_last, alu_ok, done_nx;

    assign accept       = start && state == IDLE;
    assign div_go       = accept && alu_op == OP_DIV && |BusMuxOut;
    assign mul_last     = cnt == CW'(ITER);
    assign sh           = BusMuxOut[SW-1:0];
    assign a_mag        = y[DATA_W-1] ? -y : y;
    assign b_mag        = BusMuxOut[DATA_W-1] ? -BusMuxOut : BusMuxOut;
    assign quo_fix      = (a_neg ^ b_neg) ? -quo : quo;
    assign rem_fix      = a_neg ? -rem : rem;
    assign ZHi_Data_Out = z[2*DATA_W-1:DATA_W];
    assign ZLo_Data_Out = z[DATA_W-1:0];

    seq_divider #(.W(DATA_W)) u_div (
        .clock     (clock),
        .clear     (clear),
        .start     (div_go),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

    // single-cycle results from the live Y and bus; alu_ok marks ops that finish at the start edge
    always_comb begin
        alu_ok = 1'b1;
        alu_lo = '0;
        case (alu_op)
            OP_ADD:  alu_lo = y + BusMuxOut;
            OP_SUB:  alu_lo = y - BusMuxOut;
            OP_AND:  alu_lo = y & BusMuxOut;
            OP_OR:   alu_lo = y | BusMuxOut;
            OP_SHR:  alu_lo = y >> sh;
            OP_SHRA: alu_lo = $signed(y) >>> sh;
            OP_SHL:  alu_lo = y << sh;
            OP_ROR:  alu_lo = DATA_W'({y, y} >> sh);
            OP_ROL:  alu_lo = DATA_W'(({y, y} << sh) >> DATA_W);
            OP_NEG:  alu_lo = -BusMuxOut;
            OP_NOT:  alu_lo = ~BusMuxOut;
            default: alu_ok = 1'b0;
        endcase
    end

    // one radix-2 Booth step on {acc, multiplier, q-1}; acc carries a guard bit so -2^31 operands cannot overflow
    always_comb begin
        acc    = p[2*DATA_W+1:DATA_W+1];
        m_ext  = {m_reg[DATA_W-1], m_reg};
        acc_nx = p[1:0] == 2'b01 ? acc + m_ext : p[1:0] == 2'b10 ? acc - m_ext : acc;
        p_step = {acc_nx[DATA_W], acc_nx, p[DATA_W:1]};
    end

    // FSM state register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state; a start outside IDLE is simply dropped
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = accept && alu_op == OP_MUL ? MUL_ITER : div_go ? DIV_ITER : IDLE;
            MUL_ITER: state_nx = mul_last ? IDLE : MUL_ITER;
            DIV_ITER: state_nx = div_done ? DIV_FIX : DIV_ITER;
            default:  state_nx = IDLE;
        endcase
    end

    // FSM outputs: Z write mux and the done pulse request
    always_comb begin
        z_nx    = z;
        done_nx = 1'b0;
        busy    = state != IDLE;
        case (state)
            IDLE: begin
                done_nx = accept && alu_op != OP_MUL && !div_go;
                z_nx    = accept && alu_ok ? {{DATA_W{1'b0}}, alu_lo} :
                          accept && alu_op == OP_DIV && !div_go ? {y, {DATA_W{1'b1}}} : z;
            end
            MUL_ITER: begin
                done_nx = mul_last;
                z_nx    = mul_last ? p[2*DATA_W:1] : z;
            end
            DIV_FIX: begin
                done_nx = 1'b1;
                z_nx    = {rem_fix, quo_fix};
            end
            default: ;
        endcase
    end

    // datapath registers: Y, Z, flags, captured operands and Booth iteration state
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            y        <= '0;
            z        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            m_reg    <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            p        <= '0;
            cnt      <= '0;
        end else begin
            if (Yin) y <= BusMuxOut;
            z    <= z_nx;
            done <= done_nx;
            if (accept) begin
                m_reg    <= y;
                a_neg    <= y[DATA_W-1];
                b_neg    <= BusMuxOut[DATA_W-1];
                div_zero <= alu_op == OP_DIV && !(|BusMuxOut);
                p        <= {{(DATA_W+1){1'b0}}, BusMuxOut, 1'b0};
                cnt      <= '0;
            end else if (state == MUL_ITER && !mul_last) begin
                p   <= p_step;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_z_unit.sv
// tb_alu_z_unit: directed bench with a scoreboard of expected Z/flags/latency checked on done
module tb_alu_z_unit;
    import alu_z_unit_pkg::*;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] BusMuxOut = '0;
    logic        Yin = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  alu_op = '0;
    logic        busy, done, div_zero;
    logic [31:0] ZHi_Data_Out, ZLo_Data_Out;

    typedef struct {
        string       tag;
        logic [63:0] z;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total = 0;
    logic [31:0] y_model = '0;
    logic [63:0] z_model = '0;

    alu_z_unit dut (
        .clock        (clock),
        .clear        (clear),
        .BusMuxOut    (BusMuxOut),
        .Yin          (Yin),
        .start        (start),
        .alu_op       (alu_op),
        .busy         (busy),
        .done         (done),
        .div_zero     (div_zero),
        .ZHi_Data_Out (ZHi_Data_Out),
        .ZLo_Data_Out (ZLo_Data_Out)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] zprev);
        int          s;
        longint      sa, sb_;
        logic [63:0] q, r;
        logic [31:0] lo;
        s   = int'(b[4:0]);
        sa  = $signed(a);
        sb_ = $signed(b);
        lo  = '0;
        case (op)
            OP_ADD:  lo = a + b;
            OP_SUB:  lo = a - b;
            OP_AND:  lo = a & b;
            OP_OR:   lo = a | b;
            OP_SHR:  lo = a >> s;
            OP_SHRA: lo = $signed(a) >>> s;
            OP_SHL:  lo = a << s;
            OP_ROR:  lo = (a >> s) | (a << (32 - s));
            OP_ROL:  lo = (a << s) | (a >> (32 - s));
            OP_NEG:  lo = 32'd0 - b;
            OP_NOT:  lo = ~b;
            OP_MUL:  return 64'(sa * sb_);
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = 64'(sa / sb_);
                r = 64'(sa % sb_);
                return {r[31:0], q[31:0]};
            end
            default: return zprev;
        endcase
        return {32'd0, lo};
    endfunction

    task automatic load_y(input logic [31:0] a);
        BusMuxOut = a;
        Yin       = 1'b1;
        tick();
        Yin       = 1'b0;
        y_model   = a;
    endtask

    // mode 0: plain; mode 1: Yin together with start; mode 2: Yin with mid_val one cycle into the op
    task automatic do_op(input logic [4:0] op, input logic [31:0] b, input string tag,
                         input int mode = 0, input logic [31:0] mid_val = '0);
        exp_t e;
        int   cyc;
        e.tag = tag;
        e.z   = model(op, y_model, b, z_model);
        e.dz  = (op == OP_DIV) && (b == 0);
        e.lat = op == OP_MUL ? 33 : (op == OP_DIV && b != 0) ? 34 : 0;
        sb.push_back(e);
        z_model   = e.z;
        BusMuxOut = b;
        alu_op    = op;
        start     = 1'b1;
        Yin       = mode == 1;
        tick();
        start     = 1'b0;
        Yin       = 1'b0;
        if (mode == 1) y_model = b;
        cyc = 0;
        if (e.lat != 0) check({tag, "_busy_hi"}, 64'(busy), 64'd1);
        if (mode == 2) begin
            BusMuxOut = mid_val;
            Yin       = 1'b1;
            tick();
            Yin       = 1'b0;
            y_model   = mid_val;
            cyc       = 1;
        end
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        e = sb.pop_front();
        check({e.tag, "_latency"}, 64'(cyc), 64'(e.lat));
        check({e.tag, "_z"}, {ZHi_Data_Out, ZLo_Data_Out}, e.z);
        check({e.tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
        check({e.tag, "_busy_lo"}, 64'(busy), 64'd0);
        tick();
        check({e.tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int          n_done, first_done;
        logic [63:0] mul_exp;
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        check("rst_z", {ZHi_Data_Out, ZLo_Data_Out}, 64'd0);

        load_y(32'd5);          do_op(OP_ADD, 32'd7, "add");
        check("add_spec", {ZHi_Data_Out, ZLo_Data_Out}, 64'd12);
        load_y(32'hFFFF_FFFF);  do_op(OP_ADD, 32'd1, "add_wrap");
        load_y(32'd3);          do_op(OP_SUB, 32'd5, "sub");
        load_y(32'hF0F0_1234);  do_op(OP_AND, 32'h0FF0_FF00, "and");
                                do_op(OP_OR, 32'h0FF0_FF00, "or");
        load_y(32'h8000_0000);  do_op(OP_SHR, 32'd4, "shr");
                                do_op(OP_SHRA, 32'd4, "shra");
        check("shra_spec", {ZHi_Data_Out, ZLo_Data_Out}, 64'hF800_0000);
                                do_op(OP_SHL, 32'd1, "shl");
        load_y(32'd1);          do_op(OP_ROR, 32'd1, "ror");
        check("ror_spec", {ZHi_Data_Out, ZLo_Data_Out}, 64'h8000_0000);
                                do_op(OP_ROL, 32'h21, "rol_b40");
        load_y(32'h1234_5678);  do_op(OP_ROR, 32'd0, "ror0");
                                do_op(OP_ROL, 32'd8, "rol8");
                                do_op(OP_NEG, 32'd5, "neg");
                                do_op(OP_NOT, 32'h0F0F_0F0F, "not");
                                do_op(5'd0, 32'd123, "undef_nop");

        load_y(-32'sd3);        do_op(OP_MUL, 32'd7, "mul_neg");
        check("mul_spec", {ZHi_Data_Out, ZLo_Data_Out}, 64'hFFFF_FFFF_FFFF_FFEB);
        load_y(32'h8000_0000);  do_op(OP_MUL, 32'h8000_0000, "mul_min");
        load_y(32'd12345);      do_op(OP_MUL, -32'sd678, "mul_mix");

        load_y(-32'sd17);       do_op(OP_DIV, 32'd5, "div_neg");
        check("div_spec", {ZHi_Data_Out, ZLo_Data_Out}, 64'hFFFF_FFFE_FFFF_FFFD);
        load_y(32'd17);         do_op(OP_DIV, -32'sd5, "div_negb");
        load_y(32'd9);          do_op(OP_DIV, 32'd0, "div_zero");
        check("div0_spec", {ZHi_Data_Out, ZLo_Data_Out}, 64'h0000_0009_FFFF_FFFF);
        load_y(32'h8000_0000);  do_op(OP_DIV, 32'hFFFF_FFFF, "div_ovf");
        load_y(32'd100);        do_op(OP_DIV, 32'd7, "div_pos");

        load_y(32'd10);         do_op(OP_ADD, 32'd3, "yin_with_start", 1);
                                do_op(OP_ADD, 32'd4, "y_after_start");
        load_y(-32'sd3);        do_op(OP_MUL, 32'd7, "mul_yin_busy", 2, 32'd100);
                                do_op(OP_ADD, 32'd1, "y_after_busy");

        // start while busy is dropped: one done, MUL timing unchanged
        load_y(32'd6);
        mul_exp   = model(OP_MUL, 32'd6, -32'sd9, z_model);
        BusMuxOut = -32'sd9;
        alu_op    = OP_MUL;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        repeat (4) tick();
        BusMuxOut = 32'd1;
        alu_op    = OP_ADD;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        n_done     = 0;
        first_done = -1;
        for (int c = 6; c <= 50; c++) begin
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = c - 1;
            end
            tick();
        end
        check("busy_start_done_count", 64'(n_done), 64'd1);
        check("busy_start_latency", 64'(first_done), 64'd33);
        check("busy_start_z", {ZHi_Data_Out, ZLo_Data_Out}, mul_exp);
        z_model = mul_exp;

        // clear in the middle of a multiply
        load_y(-32'sd3);
        BusMuxOut = 32'd7;
        alu_op    = OP_MUL;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        repeat (10) tick();
        clear = 1'b1;
        #1;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_z", {ZHi_Data_Out, ZLo_Data_Out}, 64'd0);
        check("clr_done", 64'(done), 64'd0);
        clear = 1'b0;
        z_model = '0;
        y_model = '0;
        n_done  = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done || busy) n_done++;
        end
        check("clr_no_done", 64'(n_done), 64'd0);
        load_y(32'd20);         do_op(OP_ADD, 32'd22, "add_after_clear");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
